// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM/WB bundle and forms the register-file write.
// It also tracks the halt state and counts retired instructions for debug and perf.
module wb_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [2:0]    out_sel,
    input  logic [DW-1:0] alu_res,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_to_reg,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] pc_plus2,
    input  logic [RW-1:0] wr_reg,
    input  logic          reg_we,
    input  logic          halt,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_reg,
    output logic          wb_we,
    output logic          wb_valid,
    output logic          halted,
    output logic [CW-1:0] retire_cnt
);

    localparam logic [2:0] SEL_BTR   = 3'd0;
    localparam logic [2:0] SEL_STRUE = 3'd1;
    localparam logic [2:0] SEL_SFALS = 3'd2;
    localparam logic [2:0] SEL_LINK  = 3'd3;
    localparam logic [2:0] SEL_LBI   = 3'd4;
    localparam logic [2:0] SEL_SLBI  = 3'd5;
    localparam logic [2:0] SEL_RES   = 3'd6;
    localparam logic [2:0] SEL_RSVD  = 3'd7;

    typedef struct packed {
        logic [2:0]    out_sel;
        logic [DW-1:0] alu_res;
        logic [DW-1:0] mem_rdata;
        logic          mem_to_reg;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc_plus2;
        logic [RW-1:0] wr_reg;
        logic          reg_we;
        logic          halt;
    } bundle_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_valid;
    bundle_t       r_bundle;
    bundle_t       w_bundle_in;
    logic [CW-1:0] r_retire_cnt;
    logic          w_run;
    logic          w_retire;
    logic [DW-1:0] w_rev;
    logic [DW-1:0] w_data;

    assign w_bundle_in = '{
        out_sel:    out_sel,
        alu_res:    alu_res,
        mem_rdata:  mem_rdata,
        mem_to_reg: mem_to_reg,
        rs_data:    rs_data,
        imm:        imm,
        pc_plus2:   pc_plus2,
        wr_reg:     wr_reg,
        reg_we:     reg_we,
        halt:       halt
    };

    assign w_run = (r_state == ST_RUN);

    // An entry retires on the edge it leaves the latch live and unsquashed.
    assign w_retire = r_valid & w_run & ~stall & ~flush;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a retiring HALT parks the stage until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_retire && r_bundle.halt) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // MEM/WB latch: flush beats stall; nothing becomes valid once halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_valid  <= in_valid & (w_state_nxt == ST_RUN);
            r_bundle <= w_bundle_in;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + CW'(1);
        end
    end

    // Bit reverse of the latched Rs operand.
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < int'(DW); i++) begin
            w_rev[i] = r_bundle.rs_data[int'(DW) - 1 - i];
        end
    end

    // Result-select mux on the latched code.
    always_comb begin
        w_data = '0;
        case (r_bundle.out_sel)
            SEL_BTR:   w_data = w_rev;
            SEL_STRUE: w_data = DW'(1);
            SEL_SFALS: w_data = '0;
            SEL_LINK:  w_data = r_bundle.pc_plus2;
            SEL_LBI:   w_data = r_bundle.imm;
            SEL_SLBI:  w_data = (r_bundle.rs_data << 8) | DW'(r_bundle.imm[7:0]);
            SEL_RES:   w_data = r_bundle.mem_to_reg ? r_bundle.mem_rdata : r_bundle.alu_res;
            SEL_RSVD:  w_data = '0;
            default:   w_data = '0;
        endcase
    end

    assign wb_data    = w_data;
    assign wb_reg     = r_bundle.wr_reg;
    assign wb_valid   = r_valid & w_run;
    assign wb_we      = r_valid & w_run & r_bundle.reg_we & ~r_bundle.halt
                        & (r_bundle.out_sel != SEL_RSVD);
    assign halted     = (r_state == ST_HALTED);
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected writes plus a retire/halt model.
module tb_wb_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, stall, flush, mem_to_reg, reg_we, halt;
    logic [2:0]    out_sel;
    logic [DW-1:0] alu_res, mem_rdata, rs_data, imm, pc_plus2;
    logic [RW-1:0] wr_reg;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_reg;
    logic          wb_we, wb_valid, halted;
    logic [CW-1:0] retire_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] rg;
        logic          we;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;

    // Reference model of latch validity, retire count and halt state.
    logic          m_valid;
    logic          m_halt_lat;
    logic          m_halted;
    logic [CW-1:0] exp_cnt;

    wb_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_sel(out_sel), .alu_res(alu_res), .mem_rdata(mem_rdata),
        .mem_to_reg(mem_to_reg), .rs_data(rs_data), .imm(imm), .pc_plus2(pc_plus2),
        .wr_reg(wr_reg), .reg_we(reg_we), .halt(halt),
        .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we), .wb_valid(wb_valid),
        .halted(halted), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        in_valid = 0; stall = 0; flush = 0; out_sel = 0; alu_res = 0; mem_rdata = 0;
        mem_to_reg = 0; rs_data = 0; imm = 0; pc_plus2 = 0; wr_reg = 0; reg_we = 0; halt = 0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_halt_lat = 0; m_halted = 0; exp_cnt = '0;
        sb.delete();
    endtask

    // One clock edge; updates the model with the inputs present before the edge.
    task automatic tick();
        logic ret;
        ret = m_valid && !m_halted && !stall && !flush;
        @(posedge clk);
        if (ret) begin
            exp_cnt = exp_cnt + CW'(1);
            if (m_halt_lat) m_halted = 1;
        end
        if (flush) m_valid = 0;
        else if (!stall) begin
            m_valid    = in_valid && !m_halted;
            m_halt_lat = halt;
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        in_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
        out_sel = 3'($urandom); alu_res = 16'($urandom); mem_rdata = 16'($urandom);
        mem_to_reg = 1'($urandom); rs_data = 16'($urandom); imm = 16'($urandom);
        pc_plus2 = 16'($urandom); wr_reg = 3'($urandom); reg_we = 1'($urandom); halt = 1'($urandom);
        model_reset();
        #3;
        @(posedge clk); #1;
        checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
        checks++; if (wb_reg !== '0) begin errors++; $display("FAIL reset_wb_reg: got %h expected 0", wb_reg); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b expected 0", wb_we); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL reset_retire_cnt: got %h expected 0", retire_cnt); end
        idle_inputs();
        rst_n = 1;
        tick();
        in_valid = 1; out_sel = 3'd6; alu_res = 16'h1234; wr_reg = 3'd5; reg_we = 1;
        sb.push_back('{16'h1234, 3'd5, 1'b1});
        tick();
        in_valid = 0;
        e = sb.pop_front();
        checks++; if (wb_data !== e.data) begin errors++; $display("FAIL first_data: got %h expected %h", wb_data, e.data); end
        checks++; if (wb_reg !== e.rg) begin errors++; $display("FAIL first_reg: got %h expected %h", wb_reg, e.rg); end
        checks++; if (wb_we !== e.we) begin errors++; $display("FAIL first_we: got %b expected %b", wb_we, e.we); end
        checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL first_cnt_before: got %h expected 0", retire_cnt); end
        tick();
        checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL first_cnt_after: got %h expected 1", retire_cnt); end
    endtask

    task automatic test_select();
        logic [2:0]    sel_t [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
        logic [DW-1:0] dat_t [9] = '{16'h8000, 16'h0001, 16'h0000, 16'h0042, 16'hFFAB,
                                     16'h01AB, 16'hBEEF, 16'h0000, 16'h1111};
        for (int i = 0; i < 9; i++) begin
            in_valid = 1; out_sel = sel_t[i]; rs_data = 16'h0001; imm = 16'hFFAB;
            pc_plus2 = 16'h0042; mem_rdata = 16'hBEEF; alu_res = 16'h1111;
            mem_to_reg = (i != 8); wr_reg = RW'(i); reg_we = 1;
            sb.push_back('{dat_t[i], RW'(i), (sel_t[i] != 3'd7)});
            tick();
            e = sb.pop_front();
            checks++; if (wb_data !== e.data) begin errors++; $display("FAIL sel%0d_data: got %h expected %h", i, wb_data, e.data); end
            checks++; if (wb_reg !== e.rg) begin errors++; $display("FAIL sel%0d_reg: got %h expected %h", i, wb_reg, e.rg); end
            checks++; if (wb_we !== e.we) begin errors++; $display("FAIL sel%0d_we: got %b expected %b", i, wb_we, e.we); end
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sel%0d_valid: got %b expected 1", i, wb_valid); end
            checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL sel%0d_cnt: got %h expected %h", i, retire_cnt, exp_cnt); end
        end
        idle_inputs();
        tick();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL sel_cnt_end: got %h expected %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_stall();
        logic [CW-1:0] c0;
        in_valid = 1; out_sel = 3'd4; imm = 16'h1357; wr_reg = 3'd2; reg_we = 1;
        sb.push_back('{16'h1357, 3'd2, 1'b1});
        tick();
        c0 = retire_cnt;
        e = sb.pop_front();
        checks++; if (wb_data !== e.data) begin errors++; $display("FAIL stall_cap_data: got %h expected %h", wb_data, e.data); end
        stall = 1; out_sel = 3'd3; pc_plus2 = 16'hAAAA; wr_reg = 3'd6;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (wb_data !== e.data) begin errors++; $display("FAIL stall%0d_data: got %h expected %h", k, wb_data, e.data); end
            checks++; if (wb_reg !== e.rg) begin errors++; $display("FAIL stall%0d_reg: got %h expected %h", k, wb_reg, e.rg); end
            checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL stall%0d_we: got %b expected 1", k, wb_we); end
            checks++; if (retire_cnt !== c0) begin errors++; $display("FAIL stall%0d_cnt: got %h expected %h", k, retire_cnt, c0); end
        end
        idle_inputs();
        tick();
        checks++; if (retire_cnt !== c0 + CW'(1)) begin errors++; $display("FAIL stall_release_cnt: got %h expected %h", retire_cnt, c0 + CW'(1)); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL stall_model_cnt: got %h expected %h", retire_cnt, exp_cnt); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b expected 0", wb_valid); end
    endtask

    task automatic test_flush();
        in_valid = 1; out_sel = 3'd1; wr_reg = 3'd3; reg_we = 1;
        sb.push_back('{16'h0001, 3'd3, 1'b1});
        tick();
        e = sb.pop_front();
        checks++; if (wb_we !== e.we) begin errors++; $display("FAIL flush_cap_we: got %b expected %b", wb_we, e.we); end
        stall = 1; flush = 1; out_sel = 3'd4; imm = 16'h7777;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid: got %b expected 0", wb_valid); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL flush_stall_we: got %b expected 0", wb_we); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL flush_stall_cnt: got %h expected %h", retire_cnt, exp_cnt); end
        stall = 0;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_lost_valid: got %b expected 0", wb_valid); end
        idle_inputs();
        tick();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL flush_end_cnt: got %h expected %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_halt();
        logic [CW-1:0] c0;
        c0 = exp_cnt;
        in_valid = 1; out_sel = 3'd4; imm = 16'h00A5; wr_reg = 3'd1; reg_we = 1;
        sb.push_back('{16'h00A5, 3'd1, 1'b1});
        tick();
        e = sb.pop_front();
        checks++; if (wb_we !== e.we) begin errors++; $display("FAIL halt_pre_we: got %b expected %b", wb_we, e.we); end
        out_sel = 3'd6; alu_res = 16'h0BAD; mem_to_reg = 0; wr_reg = 3'd4; halt = 1;
        sb.push_back('{16'h0BAD, 3'd4, 1'b0});
        tick();
        e = sb.pop_front();
        halt = 0; out_sel = 3'd4; imm = 16'h5555; wr_reg = 3'd7;
        checks++; if (wb_data !== e.data) begin errors++; $display("FAIL halt_instr_data: got %h expected %h", wb_data, e.data); end
        checks++; if (wb_we !== e.we) begin errors++; $display("FAIL halt_instr_we: got %b expected %b", wb_we, e.we); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL halt_instr_valid: got %b expected 1", wb_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (halted !== m_halted) begin errors++; $display("FAIL halted%0d: got %b expected %b", k, halted, m_halted); end
            checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL halted%0d_we: got %b expected 0", k, wb_we); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL halted%0d_valid: got %b expected 0", k, wb_valid); end
            checks++; if (retire_cnt !== c0 + CW'(2)) begin errors++; $display("FAIL halted%0d_cnt: got %h expected %h", k, retire_cnt, c0 + CW'(2)); end
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_halted: got %b expected 0", halted); end
        checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL halt_rst_cnt: got %h expected 0", retire_cnt); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        in_valid = 1; out_sel = 3'd2; wr_reg = 3'd6; reg_we = 1;
        sb.push_back('{16'h0000, 3'd6, 1'b1});
        tick();
        e = sb.pop_front();
        in_valid = 0;
        checks++; if (wb_we !== e.we) begin errors++; $display("FAIL halt_resume_we: got %b expected %b", wb_we, e.we); end
        checks++; if (wb_reg !== e.rg) begin errors++; $display("FAIL halt_resume_reg: got %h expected %h", wb_reg, e.rg); end
        tick();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL halt_resume_cnt: got %h expected %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid = 1; out_sel = 3'd2; wr_reg = 3'd1; reg_we = 1;
        for (int k = 0; k < 65536; k++) tick();
        checks++; if (retire_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_top: got %h expected ffff", retire_cnt); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_model_top: got %h expected %h", retire_cnt, exp_cnt); end
        idle_inputs();
        tick();
        checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", retire_cnt); end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1;
        test_reset();
        test_select();
        test_stall();
        test_flush();
        test_halt();
        test_wrap();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback pipeline stage directly downstream of the output-select generator.
- Latches the MEM/WB bundle: the 3-bit result-select code plus the candidate data sources.
- Forms the register-file write data, register and enable from the latched bundle.
- Tracks halt with a small FSM and counts retired instructions for the debug/perf port.

Parameters:
- DW, 16, datapath width.
- RW, 3, register-index width.
- CW, 16, retire-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM stage presents a valid instruction.
- stall  in  1  hold the latched bundle; no capture.
- flush  in  1  squash the latched bundle.
- out_sel  in  3  result-select code (0 BTR, 1 set-true, 2 set-false, 3 link, 4 LBI, 5 SLBI, 6 result, 7 reserved).
- alu_res  in  DW  ALU result.
- mem_rdata  in  DW  load data.
- mem_to_reg  in  1  code 6 takes mem_rdata instead of alu_res.
- rs_data  in  DW  Rs operand.
- imm  in  DW  sign-extended immediate.
- pc_plus2  in  DW  link address.
- wr_reg  in  RW  destination register.
- reg_we  in  1  instruction writes the register file.
- halt  in  1  instruction is HALT.
- wb_data  out  DW  register-file write data.
- wb_reg  out  RW  register-file write index.
- wb_we  out  1  register-file write enable.
- wb_valid  out  1  latched entry valid and live.
- halted  out  1  processor halted.
- retire_cnt  out  CW  retired-instruction count.

Behaviour:
- Reset asserted (async, rst_n=0):
  - Latch valid=0, all latched fields=0, FSM=RUN, retire_cnt=0.
  - Outputs: wb_data=0, wb_reg=0, wb_we=0, wb_valid=0, halted=0.
- Capture, per clock edge, in priority order:
  - flush=1: latch valid<=0, fields don't-care. Flush beats stall.
  - Else stall=1: latch holds all contents.
  - Else: latch valid<=in_valid, fields<=inputs.
- Latency: inputs captured at edge N appear on wb_* after edge N. wb_* are combinational from the latch only, never from the inputs directly.
- Data mux on the latched out_sel:
  - 0: bit-reverse of rs_data (bit i = rs_data[DW-1-i]).
  - 1: 1.
  - 2: 0.
  - 3: pc_plus2.
  - 4: imm.
  - 5: (rs_data << 8) | imm[7:0].
  - 6: mem_to_reg ? mem_rdata : alu_res.
  - 7: 0, and write suppressed.
- wb_we = latch valid & reg_we & FSM==RUN & out_sel!=7.
- wb_valid = latch valid & FSM==RUN.
- wb_reg = latched wr_reg.
- A held (stalled) entry keeps wb_we asserted every cycle; the repeated write is idempotent and allowed.
- FSM:
  - RUN→HALTED at an edge where latch valid=1, latched halt=1, stall=0 and flush=0 in that cycle.
  - The HALT instruction itself never writes: wb_we=0 whenever latched halt=1.
  - HALTED is terminal until reset. halted=1 whenever FSM is HALTED.
  - In HALTED: in_valid ignored, latch valid forced 0, wb_we=0, wb_valid=0.
- retire_cnt:
  - Increments by 1 at each edge where latch valid=1, FSM=RUN, stall=0 and flush=0.
  - A stalled entry counts once only, on the edge it leaves.
  - HALT counts as retired.
  - Wraps from all-ones to 0 with no saturation or flag.
- Simultaneous in_valid and flush: flush wins, and the incoming instruction is lost (the upstream stage must replay it).
- Reset mid-stall or mid-halt: everything returns to the reset values immediately (async). After deassertion, operation resumes in RUN at the next edge.

Test Plan:
- Reset: rst_n=0 with random inputs → all outputs 0. Deassert, then in_valid=1, out_sel=6, alu_res=16'h1234, wr_reg=5, reg_we=1 → next cycle wb_data=16'h1234, wb_reg=5, wb_we=1, retire_cnt=1 after the following edge.
- Select codes: rs_data=16'h0001, imm=16'hFFAB, pc_plus2=16'h0042 → wb_data:
  - code 0: 16'h8000.
  - code 1: 1.
  - code 2: 0.
  - code 3: 16'h0042.
  - code 4: 16'hFFAB.
  - code 5: 16'h01AB.
  - code 6 with mem_to_reg=1, mem_rdata=16'hBEEF: 16'hBEEF.
  - code 7: wb_we=0.
- Stall: capture entry, then stall=1 for 3 cycles with new inputs → wb_data unchanged, wb_we held 1, retire_cnt +1 only at the release edge.
- Flush over stall: stall=1 and flush=1 together → wb_valid=0 and wb_we=0 next cycle, retire_cnt unchanged.
- Halt: halt instruction, then further valid instructions → halted=1 after the retire edge, wb_we=0 on the HALT cycle and forever after, retire_cnt frozen. Pulse rst_n=0 → halted=0, count=0.
- Wrap: preload by streaming 65536 valid non-stalled instructions → retire_cnt returns to 0.
